syzygy_dac_playback: RTL

SYZYGY_DAC_PLAYBACK -- requirements
Module: syzygy_dac_playback

---
 rtl/syzygy_dac_pkg.sv | 17 +
 rtl/syzygy_dac_sample_ram.sv | 44 ++++
 rtl/syzygy_dac_playback.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/syzygy_dac_pkg.sv
// Shared definitions for the SYZYGY DAC sample-playback block.
//   state_e         : controller state encoding, also driven on the 'state' port
//   IdleCodeDefault : DAC midscale code driven whenever no buffer sample is output
//   SampleW/PairW   : width of one DAC sample and of one stored I/Q pair
package syzygy_dac_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StPlay = 2'd2
   } state_e;

   localparam logic [11:0] IdleCodeDefault = 12'h800;
   localparam int unsigned SampleW         = 12;
   localparam int unsigned PairW           = 2 * SampleW;

endpackage

// File: rtl/syzygy_dac_sample_ram.sv
// Simple dual-port sample buffer with a registered one-cycle read.
//   clk_i     : clock
//   wr_en_i   : write strobe; wr_data_i stored at wr_addr_i
//   wr_addr_i : write address
//   wr_data_i : write data ({I, Q})
//   rd_en_i   : read strobe; rd_data_o updated on the next edge
//   rd_addr_i : read address
//   rd_data_o : registered read data
// Contents are not reset.
module syzygy_dac_sample_ram
   import syzygy_dac_pkg::*;
#(
   parameter int unsigned AddrW = 10,
   parameter int unsigned Width = PairW
) (
   input  logic             clk_i,
   input  logic             wr_en_i,
   input  logic [AddrW-1:0] wr_addr_i,
   input  logic [Width-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic [AddrW-1:0] rd_addr_i,
   output logic [Width-1:0] rd_data_o
);

   localparam int unsigned Depth = 2 ** AddrW;

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/syzygy_dac_playback.sv
// I/Q sample-buffer loader and playback engine for a SYZYGY DAC PHY.
//   clk, reset_n           : single clock, synchronous active-low reset
//   load_start/play_start  : pulses accepted only in IDLE (load wins if both)
//   stop                   : aborts a load or a playback
//   loop_en                : wrap playback at end of buffer instead of ending
//   wr_valid/wr_ready/wr_last, wr_data_i/wr_data_q : buffer load stream
//   data_i/data_q/data_valid : samples to the DAC (IDLE_CODE when not valid)
//   state                  : 0 IDLE, 1 LOAD, 2 PLAY
//   length                 : number of stored pairs
//   loop_count             : completed wraps, saturating
module syzygy_dac_playback
   import syzygy_dac_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter logic [11:0] IDLE_CODE = IdleCodeDefault
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load_start,
   input  logic          play_start,
   input  logic          stop,
   input  logic          loop_en,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic          wr_last,
   input  logic [11:0]   wr_data_i,
   input  logic [11:0]   wr_data_q,
   output logic [11:0]   data_i,
   output logic [11:0]   data_q,
   output logic          data_valid,
   output logic [1:0]    state,
   output logic [ADDR_W:0] length,
   output logic [15:0]   loop_count
);

   localparam int unsigned      Depth    = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]  One      = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0]  LastAddr = (ADDR_W + 1)'(Depth - 1);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   length_q, length_d;
   logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
   logic [15:0]       loop_cnt_q, loop_cnt_d;

   logic              wr_fire, wr_end;
   logic              rd_issue, rd_end;
   logic              play_ok;
   logic              flush;

   logic              rd_vld_q;
   logic              data_valid_q;
   logic [11:0]       out_i_q, out_q_q;
   logic [PairW-1:0]  rd_data;

   // ---------------------------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------------------------
   assign play_ok = play_start && (length_q != '0);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (load_start) begin
               state_d = StLoad;
            end else if (play_ok) begin
               state_d = StPlay;
            end
         end
         StLoad: begin
            if (stop || wr_end) begin
               state_d = StIdle;
            end
         end
         StPlay: begin
            if (stop || (rd_end && !loop_en)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      // A beat offered in the stop cycle must not be accepted.
      wr_ready = (state_q == StLoad) && !stop;
      rd_issue = (state_q == StPlay);
   end

   assign wr_fire = wr_valid && wr_ready;
   // length_q doubles as the write address while loading.
   assign wr_end  = wr_fire && (wr_last || (length_q == LastAddr));
   assign rd_end  = rd_issue && (rd_addr_q == (length_q - One));
   // Stop during playback throws away reads still in the two-stage pipe.
   assign flush   = stop && (state_q == StPlay);

   // ---------------------------------------------------------------------------------------------
   // Counters
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      length_d   = length_q;
      rd_addr_d  = rd_addr_q;
      loop_cnt_d = loop_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (load_start) begin
               length_d = '0;
            end else if (play_ok) begin
               rd_addr_d  = '0;
               loop_cnt_d = '0;
            end
         end
         StLoad: begin
            if (wr_fire) begin
               length_d = length_q + One;
            end
         end
         StPlay: begin
            if (!stop) begin
               if (rd_end) begin
                  rd_addr_d = '0;
                  if (loop_en && (loop_cnt_q != 16'hFFFF)) begin
                     loop_cnt_d = loop_cnt_q + 16'd1;
                  end
               end else begin
                  rd_addr_d = rd_addr_q + One;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         length_q   <= '0;
         rd_addr_q  <= '0;
         loop_cnt_q <= '0;
      end else begin
         length_q   <= length_d;
         rd_addr_q  <= rd_addr_d;
         loop_cnt_q <= loop_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Sample storage
   // ---------------------------------------------------------------------------------------------
   syzygy_dac_sample_ram #(
      .AddrW (ADDR_W),
      .Width (PairW)
   ) u_ram (
      .clk_i     (clk),
      .wr_en_i   (wr_fire),
      .wr_addr_i (length_q[ADDR_W-1:0]),
      .wr_data_i ({wr_data_i, wr_data_q}),
      .rd_en_i   (rd_issue),
      .rd_addr_i (rd_addr_q[ADDR_W-1:0]),
      .rd_data_o (rd_data)
   );

   // ---------------------------------------------------------------------------------------------
   // Read pipeline: RAM register stage (rd_vld_q) then output register stage
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         rd_vld_q     <= 1'b0;
         data_valid_q <= 1'b0;
         out_i_q      <= IDLE_CODE;
         out_q_q      <= IDLE_CODE;
      end else begin
         rd_vld_q     <= rd_issue;
         data_valid_q <= rd_vld_q;
         out_i_q      <= rd_vld_q ? rd_data[PairW-1:SampleW] : IDLE_CODE;
         out_q_q      <= rd_vld_q ? rd_data[SampleW-1:0]     : IDLE_CODE;
      end
   end

   assign data_i     = out_i_q;
   assign data_q     = out_q_q;
   assign data_valid = data_valid_q;
   assign state      = state_q;
   assign length     = length_q;
   assign loop_count = loop_cnt_q;

endmodule
